// File: rtl/fb_ram_arbiter.sv
// fb_ram_arbiter: shares the single-port slice RAM between the framebuffer
// reader (priority) and the RGB writer, and raises `stream` once enough slice
// data has been primed into the RAM.
//
// Ports:
//   clk_33, rst              clock, synchronous active-high reset
//   rd_req/rd_addr/rd_gnt    reader request, address, same-cycle grant
//   rd_data/rd_valid         read data (passthrough of ram_rdata) and valid
//   wr_req/wr_addr/wr_data   writer request, address, data
//   wr_gnt                   writer same-cycle grant
//   ram_addr/ram_wdata/ram_we registered RAM drive
//   ram_rdata                RAM read data, one cycle after ram_addr
//   stream_clear/stream      priming restart / primed indication
//
// Optional feature (macro FB_ARB_STATS_EN):
//   wr_stall_cnt  saturating count of cycles the writer waited
//   max_streak    highest read-streak value seen since reset
module fb_ram_arbiter #(
    parameter int unsigned RAM_ADDR_WIDTH  = 32,
    parameter int unsigned RAM_DATA_WIDTH  = 16,
    parameter int unsigned MAX_READ_STREAK = 15,
    parameter int unsigned PRIME_WORDS     = 34560
) (
    input  logic                      clk_33,
    input  logic                      rst,
    input  logic                      rd_req,
    input  logic [RAM_ADDR_WIDTH-1:0] rd_addr,
    output logic                      rd_gnt,
    output logic [RAM_DATA_WIDTH-1:0] rd_data,
    output logic                      rd_valid,
    input  logic                      wr_req,
    input  logic [RAM_ADDR_WIDTH-1:0] wr_addr,
    input  logic [RAM_DATA_WIDTH-1:0] wr_data,
    output logic                      wr_gnt,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [RAM_DATA_WIDTH-1:0] ram_wdata,
    output logic                      ram_we,
    input  logic [RAM_DATA_WIDTH-1:0] ram_rdata,
    input  logic                      stream_clear,
    output logic                      stream
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]               wr_stall_cnt,
    output logic [7:0]                max_streak
`endif
);

    localparam int unsigned STREAK_W = 8;
    localparam logic [STREAK_W-1:0]       STREAK_MAX = STREAK_W'(MAX_READ_STREAK);
    localparam logic [RAM_ADDR_WIDTH-1:0] PRIME_MAX  = RAM_ADDR_WIDTH'(PRIME_WORDS);

    logic [STREAK_W-1:0]       streak_q, streak_d;
    logic [RAM_ADDR_WIDTH-1:0] prime_q, prime_d;
    logic                      stream_q, stream_d;
    logic [1:0]                vld_q;
    logic [RAM_ADDR_WIDTH-1:0] addr_q;
    logic [RAM_DATA_WIDTH-1:0] wdata_q;
    logic                      we_q;
    logic                      streak_hit;

    // Grant selection: reader wins contention until the writer has waited a full streak.
    always_comb begin
        streak_hit = (streak_q == STREAK_MAX);
        rd_gnt     = rd_req & ~(wr_req & streak_hit);
        wr_gnt     = wr_req & (~rd_req | streak_hit);
    end

    // Streak and priming next-state; stream_clear overrides a same-cycle write.
    always_comb begin
        streak_d = '0;
        if (rd_gnt && wr_req) begin
            streak_d = streak_hit ? streak_q : streak_q + STREAK_W'(1);
        end

        prime_d = prime_q;
        if (stream_clear) begin
            prime_d = '0;
        end else if (wr_gnt && (prime_q != PRIME_MAX)) begin
            prime_d = prime_q + RAM_ADDR_WIDTH'(1);
        end

        stream_d = stream_clear ? 1'b0 : (stream_q | (prime_d == PRIME_MAX));
    end

    // State and RAM drive registers.
    always_ff @(posedge clk_33) begin
        if (rst) begin
            streak_q <= '0;
            prime_q  <= '0;
            stream_q <= 1'b0;
            vld_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
        end else begin
            streak_q <= streak_d;
            prime_q  <= prime_d;
            stream_q <= stream_d;
            vld_q    <= {vld_q[0], rd_gnt};
            we_q     <= wr_gnt;
            if (wr_gnt) begin
                addr_q  <= wr_addr;
                wdata_q <= wr_data;
            end else if (rd_gnt) begin
                addr_q  <= rd_addr;
            end
        end
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_we    = we_q;
    assign rd_valid  = vld_q[1];
    assign rd_data   = ram_rdata;
    assign stream    = stream_q;

`ifdef FB_ARB_STATS_EN
    logic [15:0]         stall_q, stall_d;
    logic [STREAK_W-1:0] max_q, max_d;

    // Writer wait statistics.
    always_comb begin
        stall_d = stall_q;
        if (stream_clear) begin
            stall_d = '0;
        end else if (wr_req && !wr_gnt && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'(1);
        end
        max_d = (streak_d > max_q) ? streak_d : max_q;
    end

    always_ff @(posedge clk_33) begin
        if (rst) begin
            stall_q <= '0;
            max_q   <= '0;
        end else begin
            stall_q <= stall_d;
            max_q   <= max_d;
        end
    end

    assign wr_stall_cnt = stall_q;
    assign max_streak   = max_q;
`endif

endmodule

// File: doc/fb_ram_arbiter.md
Name: fb_ram_arbiter

Overview:
- Shares the single-port slice RAM between two requesters: the RGB writer (slices from the SBC) and the framebuffer reader (column fetches for the driver controller).
- The reader gets priority so the driver stream never stalls; the writer uses idle cycles, plus a guaranteed slot after a bounded read streak.
- Also sequences start-up: raises `stream` once enough slice data has been written, which gates the framebuffer.

Parameters:
- RAM_ADDR_WIDTH, 32, width of all address ports.
- RAM_DATA_WIDTH, 16, width of all data ports (RGB565 voxel).
- MAX_READ_STREAK, 15, max consecutive reader grants while the writer waits; range 1..255.
- PRIME_WORDS, 34560, granted writes required before `stream` rises (18 slices of 1920 words).

Ports:
- clk_33  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rd_req  in  1  reader requests one read this cycle
- rd_addr  in  RAM_ADDR_WIDTH  read address
- rd_gnt  out  1  reader granted this cycle (combinational)
- rd_data  out  RAM_DATA_WIDTH  read data, meaningful when rd_valid
- rd_valid  out  1  rd_data valid
- wr_req  in  1  writer requests one write this cycle
- wr_addr  in  RAM_ADDR_WIDTH  write address
- wr_data  in  RAM_DATA_WIDTH  write data
- wr_gnt  out  1  writer granted this cycle (combinational)
- ram_addr  out  RAM_ADDR_WIDTH  RAM address (registered)
- ram_wdata  out  RAM_DATA_WIDTH  RAM write data (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_rdata  in  RAM_DATA_WIDTH  RAM read data, 1 cycle after address
- stream_clear  in  1  drop `stream` and restart priming
- stream  out  1  enough data primed; framebuffer may run

Behaviour:
- Reset, synchronous on the clk_33 edge with rst=1:
  - ram_addr=0, ram_wdata=0, ram_we=0, rd_valid=0, stream=0.
  - Streak counter=0, prime counter=0, valid pipeline cleared.
- Grant logic, combinational, evaluated each cycle N:
  - Only one requester: it is granted.
  - Both requesting: reader granted, unless streak==MAX_READ_STREAK, in which case the writer is granted.
  - Neither requesting: no grant.
  - rd_gnt and wr_gnt are never both 1.
- Requester handshake:
  - A requester holds req, addr and data stable until it sees its gnt high in the same cycle.
  - Transfer happens on that edge. Deasserting req without a grant is legal; no transfer occurs.
- Streak counter (8 bit):
  - Increments when rd_gnt=1 and wr_req=1.
  - Clears when wr_gnt=1 or wr_req=0.
  - Saturates at MAX_READ_STREAK.
- RAM drive, registered at the end of cycle N:
  - rd_gnt: ram_addr<=rd_addr, ram_we<=0.
  - wr_gnt: ram_addr<=wr_addr, ram_wdata<=wr_data, ram_we<=1.
  - No grant: ram_we<=0; ram_addr and ram_wdata hold.
- Read latency:
  - The RAM sees the address in cycle N+1 and returns ram_rdata in cycle N+2.
  - rd_valid is a 2-stage registered copy of rd_gnt, so rd_valid=1 in cycle N+2.
  - rd_data = ram_rdata (combinational passthrough).
  - Back-to-back reads give 1 word per cycle; rd_valid is in grant order with no reordering.
- Prime counter (RAM_ADDR_WIDTH bits):
  - Increments on each wr_gnt; saturates at PRIME_WORDS.
  - `stream` registers high the cycle after the counter reaches PRIME_WORDS and stays high.
- stream_clear=1:
  - Next edge: stream<=0 and prime counter<=0.
  - Grants and the RAM pipeline are unaffected.
  - If wr_gnt occurs in the same cycle, the clear wins: counter=0, not 1.
- Reset mid-transfer:
  - In-flight reads are dropped; rd_valid=0 the next cycle.
  - A granted write in the reset cycle is not issued, since ram_we is forced to 0.
- Same-address read and write in consecutive cycles: no bypass; the RAM's own read-during-write behaviour applies.

Optional Feature:
- Macro FB_ARB_STATS_EN.
- Defined:
  - Adds output wr_stall_cnt (16 bit). It increments, saturating at 16'hFFFF, each cycle wr_req=1 and wr_gnt=0.
  - Cleared by rst or stream_clear.
  - Adds output max_streak (8 bit): the highest streak value seen since reset.
- Undefined: neither port exists and no counters are synthesised; all other behaviour is identical.

Test Plan:
- Reset then rd_req only, rd_addr=0x10,0x11,0x12 on consecutive cycles, ram_rdata=addr+1 -> rd_gnt=1 each cycle; ram_addr=0x10..0x12 in cycles 1..3; rd_valid=1 in cycles 2..4 with rd_data=0x11,0x12,0x13; ram_we=0 throughout.
- wr_req only, wr_addr=0x5, wr_data=0xBEEF -> wr_gnt=1 same cycle; next cycle ram_we=1, ram_addr=0x5, ram_wdata=0xBEEF; rd_valid stays 0.
- rd_req and wr_req held high for 40 cycles, MAX_READ_STREAK=15 -> pattern of 15 rd_gnt then 1 wr_gnt, repeating; never both grants; writer granted at cycles 15 and 31.
- PRIME_WORDS=4: four wr_gnt pulses -> stream=1 one cycle after the 4th; assert stream_clear together with a 5th wr_gnt -> stream=0 next cycle, and 4 more writes are needed to re-raise it.
- Grant reads at cycles 0 and 1, assert rst at cycle 1 -> rd_valid=0 at cycles 2 and 3; ram_we=0; stream=0.
- FB_ARB_STATS_EN defined: wr_req held while rd_req keeps winning for 15 cycles -> wr_stall_cnt=15, max_streak=15; rst clears both to 0.
